// File: rtl/twi_slave_logic_if.sv
// Bus-side and fabric-side signal bundle for twi_slave_logic.
interface twi_slave_logic_if;
    logic       iScl;
    logic       iSda;
    logic       oSda;
    logic [7:0] oRxData;
    logic       oRxValid;
    logic       iRxFull;
    logic [7:0] iTxData;
    logic       oTxAck;
    logic       oBusy;
    logic       oStop;

    modport slave (
        input  iScl, iSda, iRxFull, iTxData,
        output oSda, oRxData, oRxValid, oTxAck, oBusy, oStop
    );

    modport master (
        output iScl, iSda, iRxFull, iTxData,
        input  oSda, oRxData, oRxValid, oTxAck, oBusy, oStop
    );
endinterface

// File: rtl/twi_slave_logic.sv
// TWI slave responder: oversampled START/STOP detection, 7-bit address match, byte RX/TX.
// Define TWI_SLAVE_GENERAL_CALL_EN to ACK the general-call write address 8'h00.
module twi_slave_logic #(
    parameter logic [6:0]  SLAVE_ADDR  = 7'h5F,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             iPlbClk,
    input  logic             iPlbReset,
    twi_slave_logic_if.slave twi
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ADDR     = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK = 3'd2;
    localparam logic [2:0] ST_RX       = 3'd3;
    localparam logic [2:0] ST_RX_ACK   = 3'd4;
    localparam logic [2:0] ST_TX       = 3'd5;
    localparam logic [2:0] ST_TX_ACK   = 3'd6;
    localparam logic [2:0] ST_IGNORE   = 3'd7;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_hist_q, sda_hist_q;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_det, stop_det;

    logic [2:0] state_q,   state_d;
    logic [2:0] bitcnt_q,  bitcnt_d;
    logic [7:0] shift_q,   shift_d;
    logic       phase_q,   phase_d;
    logic       rw_q,      rw_d;
    logic       full_q,    full_d;
    logic       sda_q,     sda_d;
    logic [7:0] rxdata_q,  rxdata_d;
    logic       rxvalid_q, rxvalid_d;
    logic       txack_q,   txack_d;
    logic       busy_q,    busy_d;
    logic       stop_q,    stop_d;

    logic [7:0] rx_byte;
    logic       addr_hit;

    always_ff @(posedge iPlbClk) begin
        if (iPlbReset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], twi.iScl};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], twi.iSda};
            scl_hist_q <= scl_sync_q[SYNC_STAGES-1];
            sda_hist_q <= sda_sync_q[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_hist_q;
    assign scl_fall  = ~scl_s & scl_hist_q;
    assign start_det = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
    assign stop_det  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;

    assign rx_byte = {shift_q[6:0], sda_s};

`ifdef TWI_SLAVE_GENERAL_CALL_EN
    assign addr_hit = (rx_byte[7:1] == SLAVE_ADDR) || (rx_byte == 8'h00);
`else
    assign addr_hit = (rx_byte[7:1] == SLAVE_ADDR);
`endif

    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        phase_d   = phase_q;
        rw_d      = rw_q;
        full_d    = full_q;
        sda_d     = sda_q;
        rxdata_d  = rxdata_q;
        busy_d    = busy_q;
        rxvalid_d = 1'b0;
        txack_d   = 1'b0;
        stop_d    = 1'b0;

        if (start_det) begin
            sda_d    = 1'b1;
            bitcnt_d = '0;
            busy_d   = 1'b0;
            phase_d  = 1'b0;
            state_d  = ST_ADDR;
        end else if (stop_det) begin
            sda_d   = 1'b1;
            busy_d  = 1'b0;
            stop_d  = busy_q;
            phase_d = 1'b0;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: sda_d = 1'b1;
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d  = rx_byte;
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            if (addr_hit) begin
                                busy_d  = 1'b1;
                                rw_d    = rx_byte[0];
                                phase_d = 1'b0;
                                state_d = ST_ADDR_ACK;
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end
                    end
                end
                // phase_q marks that the ACK low has been driven; the second fall ends the slot.
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_d   = 1'b0;
                            phase_d = 1'b1;
                        end else begin
                            phase_d  = 1'b0;
                            bitcnt_d = '0;
                            if (rw_q) begin
                                shift_d = {twi.iTxData[6:0], 1'b0};
                                sda_d   = twi.iTxData[7];
                                txack_d = 1'b1;
                                state_d = ST_TX;
                            end else begin
                                sda_d   = 1'b1;
                                state_d = ST_RX;
                            end
                        end
                    end
                end
                ST_RX: begin
                    if (scl_rise) begin
                        shift_d  = rx_byte;
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            rxdata_d  = rx_byte;
                            rxvalid_d = 1'b1;
                            phase_d   = 1'b0;
                            state_d   = ST_RX_ACK;
                        end
                    end
                end
                ST_RX_ACK: begin
                    if (rxvalid_q)
                        full_d = twi.iRxFull;
                    if (scl_fall) begin
                        if (!phase_q) begin
                            if (full_q) begin
                                sda_d   = 1'b1;
                                state_d = ST_IGNORE;
                            end else begin
                                sda_d   = 1'b0;
                                phase_d = 1'b1;
                            end
                        end else begin
                            sda_d   = 1'b1;
                            phase_d = 1'b0;
                            state_d = ST_RX;
                        end
                    end
                end
                ST_TX: begin
                    if (scl_fall) begin
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            sda_d   = 1'b1;
                            phase_d = 1'b0;
                            state_d = ST_TX_ACK;
                        end else begin
                            sda_d   = shift_q[7];
                            shift_d = {shift_q[6:0], 1'b0};
                        end
                    end
                end
                ST_TX_ACK: begin
                    if (scl_rise) begin
                        if (sda_s) state_d = ST_IGNORE;
                        else       phase_d = 1'b1;
                    end else if (scl_fall && phase_q) begin
                        phase_d  = 1'b0;
                        bitcnt_d = '0;
                        shift_d  = {twi.iTxData[6:0], 1'b0};
                        sda_d    = twi.iTxData[7];
                        txack_d  = 1'b1;
                        state_d  = ST_TX;
                    end
                end
                ST_IGNORE: sda_d = 1'b1;
                default: begin
                    sda_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge iPlbClk) begin
        if (iPlbReset) begin
            state_q   <= ST_IDLE;
            bitcnt_q  <= '0;
            shift_q   <= '0;
            phase_q   <= 1'b0;
            rw_q      <= 1'b0;
            full_q    <= 1'b0;
            sda_q     <= 1'b1;
            rxdata_q  <= '0;
            rxvalid_q <= 1'b0;
            txack_q   <= 1'b0;
            busy_q    <= 1'b0;
            stop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            shift_q   <= shift_d;
            phase_q   <= phase_d;
            rw_q      <= rw_d;
            full_q    <= full_d;
            sda_q     <= sda_d;
            rxdata_q  <= rxdata_d;
            rxvalid_q <= rxvalid_d;
            txack_q   <= txack_d;
            busy_q    <= busy_d;
            stop_q    <= stop_d;
        end
    end

    assign twi.oSda     = sda_q;
    assign twi.oRxData  = rxdata_q;
    assign twi.oRxValid = rxvalid_q;
    assign twi.oTxAck   = txack_q;
    assign twi.oBusy    = busy_q;
    assign twi.oStop    = stop_q;

endmodule

// File: tb/tb_twi_slave_logic.sv
// Bench for twi_slave_logic: bit-level TWI master, transaction-level expectations.
module tb_twi_slave_logic;

    localparam int LOW  = 10;
    localparam int HIGH = 10;
`ifdef TWI_SLAVE_GENERAL_CALL_EN
    localparam bit GC_EN = 1'b1;
`else
    localparam bit GC_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic m_scl, m_sda, rx_full;
    always #5 clk = ~clk;

    twi_slave_logic_if twi ();

    int n_checks = 0;
    int n_errors = 0;
    int rx_cnt = 0, tx_cnt = 0, stop_cnt = 0, low_cnt = 0;
    int tx_base;
    logic [7:0] rx_log [256];
    logic [7:0] tx_q [8];
    logic [7:0] wr_q [8];

    assign twi.iScl    = m_scl;
    assign twi.iSda    = m_sda & twi.oSda;
    assign twi.iRxFull = rx_full;
    assign twi.iTxData = tx_q[3'(tx_cnt - tx_base)];

    twi_slave_logic #(.SLAVE_ADDR(7'h5F), .SYNC_STAGES(2)) dut (
        .iPlbClk  (clk),
        .iPlbReset(rst),
        .twi      (twi)
    );

    always @(negedge clk) begin
        if (twi.oRxValid) begin
            rx_log[rx_cnt % 256] = twi.oRxData;
            rx_cnt++;
        end
        if (twi.oTxAck) tx_cnt++;
        if (twi.oStop)  stop_cnt++;
        if (!twi.oSda)  low_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clk_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_bit(input logic b);
        clk_wait(2); m_sda = b;
        clk_wait(LOW - 2); m_scl = 1'b1;
        clk_wait(HIGH); m_scl = 1'b0;
    endtask

    task automatic read_bit(output logic b);
        clk_wait(2); m_sda = 1'b1;
        clk_wait(LOW - 2); m_scl = 1'b1;
        clk_wait(HIGH / 2); #1 b = twi.iSda;
        clk_wait(HIGH / 2); m_scl = 1'b0;
    endtask

    task automatic i2c_start();
        if (m_scl == 1'b0) begin
            clk_wait(2); m_sda = 1'b1;
            clk_wait(LOW - 2); m_scl = 1'b1;
        end
        clk_wait(HIGH); m_sda = 1'b0;
        clk_wait(HIGH); m_scl = 1'b0;
    endtask

    task automatic i2c_stop();
        clk_wait(2); m_sda = 1'b0;
        clk_wait(LOW - 2); m_scl = 1'b1;
        clk_wait(HIGH); m_sda = 1'b1;
        clk_wait(HIGH);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic acked);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(b);
        acked = ~b;
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] d);
        logic b;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            read_bit(b);
            d = {d[6:0], b};
        end
        write_bit(~ack);
    endtask

    // Write transaction; the fabric reports full from byte index full_idx onward.
    task automatic do_write(input logic [7:0] addr, input int n, input int full_idx);
        int rx0, st0, lo0, exp_rx;
        logic ack, hit;
        rx0 = rx_cnt; st0 = stop_cnt; lo0 = low_cnt;
        hit = (addr == 8'hBE) || (GC_EN && addr == 8'h00);
        i2c_start();
        write_byte(addr, ack);
        check_eq("wr_addr_ack", ack, hit);
        check_eq("wr_busy", twi.oBusy, hit);
        for (int i = 0; i < n; i++) begin
            rx_full = (i >= full_idx);
            write_byte(wr_q[i], ack);
            check_eq("wr_data_ack", ack, hit && (i < full_idx));
        end
        rx_full = 1'b0;
        i2c_stop();
        clk_wait(4);
        exp_rx = hit ? ((full_idx < n) ? full_idx + 1 : n) : 0;
        check_eq("wr_rx_count", rx_cnt - rx0, exp_rx);
        for (int i = 0; i < exp_rx; i++)
            check_eq("wr_rx_data", rx_log[(rx0 + i) % 256], wr_q[i]);
        check_eq("wr_stop_pulse", stop_cnt - st0, hit);
        check_eq("wr_busy_end", twi.oBusy, 0);
        if (!hit) check_eq("wr_no_drive", low_cnt - lo0, 0);
    endtask

    // Read transaction of n bytes from tx_q; master ACKs all but the last.
    task automatic do_read(input logic [7:0] addr, input int n);
        int tx0, st0;
        logic ack, hit;
        logic [7:0] d;
        tx0 = tx_cnt; st0 = stop_cnt; tx_base = tx_cnt;
        hit = (addr == 8'hBF);
        i2c_start();
        write_byte(addr, ack);
        check_eq("rd_addr_ack", ack, hit);
        if (hit) begin
            for (int i = 0; i < n; i++) begin
                read_byte(i < n - 1, d);
                check_eq("rd_data", d, tx_q[i]);
            end
        end
        check_eq("rd_sda_released", twi.oSda, 1);
        i2c_stop();
        clk_wait(4);
        check_eq("rd_txack_count", tx_cnt - tx0, hit ? n : 0);
        check_eq("rd_stop_pulse", stop_cnt - st0, hit);
        check_eq("rd_busy_end", twi.oBusy, 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int rx0, tx0, st0, lo0;
        logic ack, b;
        logic [7:0] d;

        m_scl = 1'b1; m_sda = 1'b1; rx_full = 1'b0; tx_base = 0;
        for (int i = 0; i < 8; i++) begin tx_q[i] = '0; wr_q[i] = '0; end
        rst = 1'b1;
        clk_wait(3);
        check_eq("rst_sda", twi.oSda, 1);
        check_eq("rst_rxdata", twi.oRxData, 0);
        check_eq("rst_rxvalid", twi.oRxValid, 0);
        check_eq("rst_txack", twi.oTxAck, 0);
        check_eq("rst_busy", twi.oBusy, 0);
        check_eq("rst_stop", twi.oStop, 0);
        rst = 1'b0;
        clk_wait(5);

        wr_q[0] = 8'hEF; do_write(8'hBE, 1, 8);
        wr_q[0] = 8'h4A; do_write(8'h78, 1, 8);
        tx_q[0] = 8'hE3; do_read(8'hBF, 1);
        tx_q[0] = 8'h12; tx_q[1] = 8'h34; do_read(8'hBF, 2);
        wr_q[0] = 8'hA5; wr_q[1] = 8'h5A; do_write(8'hBE, 2, 0);
        wr_q[0] = 8'h9C; do_write(8'h00, 1, 8);
        tx_q[0] = 8'h77; do_read(8'h01, 1);

        // Write then repeated START into a read: no oStop at the repeated START.
        rx0 = rx_cnt; tx0 = tx_cnt; st0 = stop_cnt;
        tx_q[0] = 8'hC6; tx_base = tx_cnt;
        i2c_start();
        write_byte(8'hBE, ack); check_eq("sr_wr_addr_ack", ack, 1);
        write_byte(8'h3C, ack); check_eq("sr_wr_data_ack", ack, 1);
        i2c_start();
        check_eq("sr_busy_cleared", twi.oBusy, 0);
        check_eq("sr_no_stop", stop_cnt - st0, 0);
        write_byte(8'hBF, ack); check_eq("sr_rd_addr_ack", ack, 1);
        read_byte(1'b0, d); check_eq("sr_rd_data", d, 8'hC6);
        i2c_stop(); clk_wait(4);
        check_eq("sr_rx_count", rx_cnt - rx0, 1);
        check_eq("sr_rx_data", rx_log[rx0 % 256], 8'h3C);
        check_eq("sr_tx_count", tx_cnt - tx0, 1);
        check_eq("sr_stop_count", stop_cnt - st0, 1);

        // Reset during the third bit of a TX byte that drives all zeros.
        tx_q[0] = 8'h00; tx_base = tx_cnt;
        i2c_start();
        write_byte(8'hBF, ack); check_eq("rr_addr_ack", ack, 1);
        read_bit(b); read_bit(b);
        clk_wait(4);
        check_eq("rr_sda_driving", twi.oSda, 0);
        rst = 1'b1; clk_wait(1); rst = 1'b0;
        check_eq("rr_sda_after_rst", twi.oSda, 1);
        check_eq("rr_busy_after_rst", twi.oBusy, 0);
        rx0 = rx_cnt; tx0 = tx_cnt; st0 = stop_cnt; lo0 = low_cnt;
        clk_wait(LOW - 4); m_scl = 1'b1; clk_wait(HIGH); m_scl = 1'b0;
        for (int i = 0; i < 5; i++) read_bit(b);
        write_bit(1'b0);
        i2c_stop(); clk_wait(4);
        check_eq("rr_quiet_low", low_cnt - lo0, 0);
        check_eq("rr_quiet_rx", rx_cnt - rx0, 0);
        check_eq("rr_quiet_tx", tx_cnt - tx0, 0);
        check_eq("rr_quiet_stop", stop_cnt - st0, 0);
        wr_q[0] = 8'h55; do_write(8'hBE, 1, 8);
        check_eq("rr_rxdata", twi.oRxData, 8'h55);

        for (int t = 0; t < 20; t++) begin
            int n;
            logic [7:0] a;
            if ($urandom_range(0, 1) == 0) begin
                n = $urandom_range(1, 4);
                a = ($urandom_range(0, 9) < 6) ? 8'hBE : {7'($urandom), 1'b0};
                for (int i = 0; i < n; i++) wr_q[i] = 8'($urandom);
                do_write(a, n, $urandom_range(0, n));
            end else begin
                n = $urandom_range(1, 3);
                a = ($urandom_range(0, 9) < 7) ? 8'hBF : {7'($urandom), 1'b1};
                for (int i = 0; i < n; i++) tx_q[i] = 8'($urandom);
                do_read(a, n);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/twi_slave_logic.md
Name: twi_slave_logic

Overview:
- TWI (I2C-style) slave responder: the far end of the TWI master link, used for bench loopback and for on-board peripherals hosted in fabric.
- Oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit address, and acknowledges.
- Write transfers: each received byte is delivered to fabric.
- Read transfers: bytes are taken from fabric and shifted out MSB first.

Parameters:
SLAVE_ADDR, 7'h5F, 7-bit slave address; address byte 8'hBE = write, 8'hBF = read.
SYNC_STAGES, 2, synchroniser depth on iScl/iSda (min 2).

Ports:
iPlbClk  in  1  system clock, all logic on rising edge.
iPlbReset  in  1  synchronous, active-high reset.
iScl  in  1  bus SCL (resolved wire level).
iSda  in  1  bus SDA (resolved wire level).
oSda  out  1  open-drain drive: 0 = pull SDA low, 1 = release.
oRxData  out  8  last byte received in a write transfer.
oRxValid  out  1  one-cycle pulse when oRxData updates.
iRxFull  in  1  fabric cannot take a byte; the byte is NACKed.
iTxData  in  8  next byte to send in a read transfer.
oTxAck  out  1  one-cycle pulse when iTxData is loaded into the shifter.
oBusy  out  1  high from an addressed START until STOP.
oStop  out  1  one-cycle pulse on a STOP detected while oBusy.

Behaviour:
- Reset values: oSda=1, oRxData=0, oRxValid=0, oTxAck=0, oBusy=0, oStop=0; state IDLE; synchroniser flops = 1.
- Sampling: iScl/iSda pass SYNC_STAGES flops plus one history flop. SCL rise/fall = sync level change.
- START: SDA 1->0 while SCL high. STOP: SDA 0->1 while SCL high. Both are honoured in every state and take priority over data edges.
- Data is sampled on the detected SCL rise. oSda changes only on the cycle after a detected SCL fall.
- States:
  - IDLE: oSda=1; START -> ADDR.
  - ADDR: shift 8 bits on SCL rises. After bit 8:
    - byte[7:1]==SLAVE_ADDR -> ADDR_ACK, oBusy=1;
    - else -> IGNORE, oSda stays 1.
  - ADDR_ACK: on the next SCL fall drive oSda=0; on the following SCL fall:
    - R/W=0 -> RX;
    - R/W=1 -> load iTxData, pulse oTxAck, drive MSB, -> TX.
  - RX: shift 8 bits on SCL rises. On bit 8: oRxData<=byte, oRxValid pulses that cycle, -> RX_ACK.
  - RX_ACK: ACK (drive 0 for one SCL low+high period) if iRxFull was 0 when oRxValid pulsed, then -> RX. Else release SDA and -> IGNORE.
  - TX: drive the next bit on each SCL fall. After the 8th bit's SCL fall, release SDA -> TX_ACK.
  - TX_ACK: sample SDA on SCL rise.
    - 0 (master ACK): on the next SCL fall load iTxData, pulse oTxAck, drive MSB, -> TX.
    - 1 (master NACK): -> IGNORE.
  - IGNORE: oSda=1 until START (-> ADDR) or STOP (-> IDLE).
- Repeated START in any state: release SDA, clear the bit counter, oBusy=0, -> ADDR. No oStop pulse.
- STOP in any state: release SDA, -> IDLE, oBusy=0. oStop pulses only if oBusy was 1.
- START and STOP cannot occur on the same cycle (SCL high, single SDA edge).
- Bit counter is 3 bits and wraps 7->0 at each byte boundary.
- Reset mid-transfer: oSda=1 on the cycle after reset is sampled. Bus activity is ignored until a new START after reset deasserts.
- Minimum timing: each SCL half-period must be at least SYNC_STAGES+3 iPlbClk cycles.

Optional Feature:
- TWI_SLAVE_GENERAL_CALL_EN defined: address byte 8'h00 (general call, write) is ACKed and handled as a write to this slave. oRxData/oRxValid behave as for a normal write.
- Macro undefined: 8'h00 is treated as a mismatch and the slave goes to IGNORE.
- The read-direction address 8'h01 is never ACKed, with or without the macro.

Test Plan:
1. Master writes 8'hEF to address byte 8'hBE, iRxFull=0 -> both ACK slots low; oRxData=8'hEF with one oRxValid pulse; oStop pulses; oBusy returns 0.
2. Master writes 8'h4A to address byte 8'h78 -> SDA never driven low by the slave; no oRxValid; no oStop; master sees address NACK.
3. Master reads from 8'hBF, iTxData=8'hE3, master NACKs -> master receives 8'hE3; exactly one oTxAck; slave releases SDA before STOP.
4. Read 8'hBF, master ACKs byte 1 (iTxData=8'h12) then NACKs byte 2 (iTxData=8'h34) -> master gets 12,34; two oTxAck pulses.
5. Write 8'hBE with iRxFull=1 -> address ACKed; oRxValid pulses with the byte; data slot NACKed; a second data byte is ignored.
6. Assert iPlbReset during bit 3 of a TX byte -> oSda=1 next cycle; no outputs until a new START; a following write of 8'hBE/8'h55 yields oRxData=8'h55.
